// File: rtl/toggle_debouncer.sv
// Push-button debouncer: two-flop synchronizer, then a four-state qualification
// FSM that emits one registered toggle strobe per accepted press.
module toggle_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic T,
  output logic level,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             s1_reg, btn_s_reg;
  logic             t_reg, t_next;
  logic             level_reg, level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      s1_reg    <= 1'b0;
      btn_s_reg <= 1'b0;
      t_reg     <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      s1_reg    <= btn_in;
      btn_s_reg <= s1_reg;
      t_reg     <= t_next;
      level_reg <= level_next;
    end
  end

  // The strobe defaults low, so it can only ever last one cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    t_next     = 1'b0;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (btn_s_reg) begin
          state_next = CHK_PRESS;
          cnt_next   = CNT_ONE;
        end
      end
      CHK_PRESS: begin
        if (!btn_s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = HELD;
          level_next = 1'b1;
          t_next     = enable;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s_reg) begin
          state_next = CHK_REL;
          cnt_next   = CNT_ONE;
        end
      end
      CHK_REL: begin
        if (btn_s_reg) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = IDLE;
          level_next = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign T     = t_reg;
  assign level = level_reg;
  assign busy  = (state_reg == CHK_PRESS) || (state_reg == CHK_REL);

endmodule

// File: tb/tb_toggle_debouncer.sv
// Directed bench for toggle_debouncer: a run-length model of the filtered button
// pushes expected outputs per edge, which are popped and compared after the edge.
module tb_toggle_debouncer;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic enable = 1'b1;
  logic T, level, busy;

  toggle_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .enable (enable),
    .T      (T),
    .level  (level),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic t;
    logic lvl;
    logic bsy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;
  int   tcount = 0;
  logic busy_seen = 1'b0;

  // Reference: two-sample delay line plus the length of the current run of
  // filtered samples that disagree with the accepted level.
  logic m_d1 = 1'b0, m_d2 = 1'b0, m_level = 1'b0, m_t = 1'b0;
  int   m_run = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s edge %0d observed=%b expected=%b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic e, input logic r);
    exp_t x;
    btn_in = b;
    enable = e;
    reset  = r;
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_run = 0; m_level = 1'b0; m_t = 1'b0;
    end else begin
      m_t = 1'b0;
      if (m_d2 != m_level) m_run++;
      else m_run = 0;
      if (m_run == STABLE + 1) begin
        m_level = ~m_level;
        m_t     = m_level & e;
        m_run   = 0;
      end
      m_d2 = m_d1;
      m_d1 = b;
    end
    x.t = m_t; x.lvl = m_level; x.bsy = (m_run != 0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    edge_no++;
    x = sb.pop_front();
    $display("edge %0d btn=%b en=%b rst=%b -> T=%b level=%b busy=%b", edge_no, b, e, r, T,
             level, busy);
    if (T === 1'b1) tcount++;
    if (busy === 1'b1) busy_seen = 1'b1;
    chk("T", T, x.t);
    chk("level", level, x.lvl);
    chk("busy", busy, x.bsy);
  endtask

  initial begin
    // Reset, then clean press sampled first at edge 10.
    step(0, 1, 1); step(0, 1, 1);
    chk("reset_T", T, 1'b0);
    chk("reset_level", level, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (7) step(0, 1, 0);
    tcount = 0;
    repeat (3) step(1, 1, 0);
    chk("clean_busy_e12", busy, 1'b1);
    repeat (3) step(1, 1, 0);
    chk("clean_T_e15", T, 1'b0);
    chk("clean_level_e15", level, 1'b0);
    step(1, 1, 0);
    chk("clean_T_e16", T, 1'b1);
    chk("clean_level_e16", level, 1'b1);
    step(1, 1, 0);
    chk("clean_T_e17", T, 1'b0);
    repeat (3) step(1, 1, 0);
    chk_cnt("clean_pulses", tcount, 1);
    repeat (10) step(0, 1, 0);
    chk("clean_released", level, 1'b0);

    // Bounce on press, then stable hold.
    tcount = 0;
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
    repeat (12) step(1, 1, 0);
    chk_cnt("bounce_pulses", tcount, 1);
    chk("bounce_level", level, 1'b1);

    // Release with a 2-cycle glitch back to pressed.
    tcount = 0;
    step(0, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    chk("release_glitch_level", level, 1'b1);
    repeat (8) step(0, 1, 0);
    chk("release_level", level, 1'b0);
    chk_cnt("release_pulses", tcount, 0);

    // Enable low at acceptance, raised while held.
    tcount = 0;
    repeat (8) step(1, 0, 0);
    chk("gate_level", level, 1'b1);
    repeat (4) step(1, 1, 0);
    chk_cnt("gate_pulses", tcount, 0);
    repeat (10) step(0, 1, 0);

    // Reset while in CHK_PRESS with cnt=3; press held through reset.
    tcount = 0;
    repeat (5) step(1, 1, 0);
    chk("midchk_busy", busy, 1'b1);
    step(1, 1, 1);
    chk("midchk_rst_T", T, 1'b0);
    chk("midchk_rst_level", level, 1'b0);
    chk("midchk_rst_busy", busy, 1'b0);
    repeat (6) step(1, 1, 0);
    chk("midchk_T_early", T, 1'b0);
    step(1, 1, 0);
    chk("midchk_T_accept", T, 1'b1);
    repeat (3) step(1, 1, 0);
    chk_cnt("midchk_pulses", tcount, 1);
    repeat (10) step(0, 1, 0);

    // Short 4-cycle glitch.
    tcount = 0;
    busy_seen = 1'b0;
    repeat (4) step(1, 1, 0);
    repeat (10) step(0, 1, 0);
    chk_cnt("glitch_pulses", tcount, 0);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_end", busy, 1'b0);
    chk("glitch_level", level, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
